maxpool_window_gen: RTL and testbench

MAXPOOL_WINDOW_GEN -- requirements
Module: maxpool_window_gen

---
 rtl/maxpool_window_gen_if.sv | 22 ++
 rtl/maxpool_window_gen.sv | 87 ++++++++
 tb/tb_maxpool_window_gen.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_window_gen_if.sv
// maxpool_window_gen_if: raster pixel input and 2x2 window output handshake bundle.
interface maxpool_window_gen_if #(parameter int in_length = 8);
    logic [in_length-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [in_length-1:0] w_tl;
    logic [in_length-1:0] w_tr;
    logic [in_length-1:0] w_bl;
    logic [in_length-1:0] w_br;
    logic                 win_valid;
    logic                 out_ready;
    logic                 win_last;
    logic                 frame_done;
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, w_tl, w_tr, w_bl, w_br, win_valid, win_last, frame_done
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, w_tl, w_tr, w_bl, w_br, win_valid, win_last, frame_done
    );
endinterface

// File: rtl/maxpool_window_gen.sv
// maxpool_window_gen: turns a raster pixel stream into non-overlapping 2x2 windows,
// buffering even rows in a line buffer and emitting one window per odd-row/odd-col pixel.
module maxpool_window_gen #(
    parameter int in_length = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input logic clk,
    input logic reset,
    maxpool_window_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [in_length-1:0] r_line_buf [IMG_W];
    logic [in_length-1:0] r_hold;
    logic [in_length-1:0] r_tl, r_tr, r_bl, r_br;
    logic                 r_win_valid;
    logic                 r_win_last;
    logic                 r_frame_done;

    logic          w_ready;
    logic          w_accept;
    logic          w_load;
    logic          w_col_end;
    logic          w_row_end;
    logic [CW-1:0] w_col_pair;

    assign w_ready    = !r_win_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_ready;
    assign w_col_end  = r_col == CW'(IMG_W - 1);
    assign w_row_end  = r_row == RW'(IMG_H - 1);
    assign w_load     = w_accept && r_row[0] && r_col[0];
    assign w_col_pair = r_col & ~CW'(1);

    assign bus.in_ready   = w_ready;
    assign bus.w_tl       = r_tl;
    assign bus.w_tr       = r_tr;
    assign bus.w_bl       = r_bl;
    assign bus.w_br       = r_br;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_last   = r_win_last;
    assign bus.frame_done = r_frame_done;

    // Pixel storage is never exposed before being written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0])
            r_line_buf[r_col] <= bus.in_data;
        if (w_accept && r_row[0] && !r_col[0])
            r_hold <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col        <= '0;
            r_row        <= '0;
            r_tl         <= '0;
            r_tr         <= '0;
            r_bl         <= '0;
            r_br         <= '0;
            r_win_valid  <= 1'b0;
            r_win_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_col <= w_col_end ? '0 : r_col + CW'(1);
                if (w_col_end)
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
            end
            r_frame_done <= w_accept && w_col_end && w_row_end;
            // A load only happens on an accepted pixel, which implies any held window was taken.
            if (w_load) begin
                r_tl        <= r_line_buf[w_col_pair];
                r_tr        <= r_line_buf[r_col];
                r_bl        <= r_hold;
                r_br        <= bus.in_data;
                r_win_valid <= 1'b1;
                r_win_last  <= w_col_end && w_row_end;
            end else if (bus.out_ready) begin
                r_win_valid <= 1'b0;
                r_win_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_maxpool_window_gen.sv
// tb_maxpool_window_gen: directed checks of a 4x2 instance and a randomised-backpressure 8x8 instance.
module tb_maxpool_window_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    int fd4 = 0;
    int fd8 = 0;
    logic [32:0] q4[$];
    logic [32:0] q8[$];

    always #5 clk = ~clk;

    maxpool_window_gen_if #(.in_length(8)) bus4();
    maxpool_window_gen_if #(.in_length(8)) bus8();

    maxpool_window_gen #(.in_length(8), .IMG_W(4), .IMG_H(2)) d4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    maxpool_window_gen #(.in_length(8), .IMG_W(8), .IMG_H(8)) d8 (.clk(clk), .reset(reset), .bus(bus8.slave));

    always @(negedge clk) begin
        if (bus4.win_valid && bus4.out_ready)
            q4.push_back({bus4.win_last, bus4.w_tl, bus4.w_tr, bus4.w_bl, bus4.w_br});
        if (bus8.win_valid && bus8.out_ready)
            q8.push_back({bus8.win_last, bus8.w_tl, bus8.w_tr, bus8.w_bl, bus8.w_br});
        if (bus4.frame_done) fd4++;
        if (bus8.frame_done) fd8++;
    end

    function automatic logic [32:0] win(input logic l, input logic [7:0] a, b, c, d);
        return {l, a, b, c, d};
    endfunction

    function automatic logic [7:0] max4(input logic [32:0] x);
        logic [7:0] m;
        m = x[31:24];
        if (x[23:16] > m) m = x[23:16];
        if (x[15:8] > m) m = x[15:8];
        if (x[7:0] > m) m = x[7:0];
        return m;
    endfunction

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * 8 + c) * 3 + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] p);
        logic acc;
        acc = 1'b0;
        bus4.in_data = p;
        bus4.in_valid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus4.in_ready;
            tick();
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL push4_timeout pixel=%0d accepted=0 required=1", p);
        end
    endtask

    task automatic push8(input logic [7:0] p);
        logic acc;
        acc = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'($urandom_range(0, 1));
        tick();
        bus8.in_data = p;
        bus8.in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            bus8.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus8.in_ready;
            tick();
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL push8_timeout pixel=%0d accepted=0 required=1", p);
        end
    endtask

    task automatic test_reset();
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({bus4.win_valid, bus4.win_last, bus4.frame_done, bus4.w_tl, bus4.w_tr, bus4.w_bl, bus4.w_br} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs_4x2 got=%h required=0", {bus4.win_valid, bus4.win_last, bus4.frame_done, bus4.w_tl, bus4.w_tr, bus4.w_bl, bus4.w_br});
        end
        checks++;
        if ({bus8.win_valid, bus8.win_last, bus8.frame_done, bus8.w_tl, bus8.w_tr, bus8.w_bl, bus8.w_br} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs_8x8 got=%h required=0", {bus8.win_valid, bus8.win_last, bus8.frame_done, bus8.w_tl, bus8.w_tr, bus8.w_bl, bus8.w_br});
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus4.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got=%b required=1", bus4.in_ready);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [32:0] e[2];
        int b, f;
        e = '{win(1'b0, 8'd1, 8'd2, 8'd5, 8'd6), win(1'b1, 8'd3, 8'd4, 8'd7, 8'd8)};
        b = q4.size(); f = fd4;
        bus4.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push4(8'(i));
        bus4.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (q4.size() - b !== 2) begin
            failures++;
            $display("FAIL stream_count got=%0d required=2", q4.size() - b);
        end
        for (int i = 0; i < 2 && b + i < q4.size(); i++) begin
            checks++;
            if (q4[b+i] !== e[i]) begin
                failures++;
                $display("FAIL stream_win%0d got=%h required=%h", i, q4[b+i], e[i]);
            end
            checks++;
            if (max4(q4[b+i]) !== e[i][7:0]) begin
                failures++;
                $display("FAIL stream_max%0d got=%0d required=%0d", i, max4(q4[b+i]), e[i][7:0]);
            end
        end
        checks++;
        if (fd4 - f !== 1) begin
            failures++;
            $display("FAIL stream_frame_done got=%0d required=1", fd4 - f);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e[2];
        int b, f;
        e = '{win(1'b0, 8'd1, 8'd2, 8'd5, 8'd6), win(1'b1, 8'd3, 8'd4, 8'd7, 8'd8)};
        b = q4.size(); f = fd4;
        bus4.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push4(8'(i));
        bus4.in_data = 8'd7;
        bus4.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus4.win_valid, bus4.in_ready, bus4.w_tl, bus4.w_tr, bus4.w_bl, bus4.w_br} !== {2'b10, 8'd1, 8'd2, 8'd5, 8'd6}) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h required=%h", i, {bus4.win_valid, bus4.in_ready, bus4.w_tl, bus4.w_tr, bus4.w_bl, bus4.w_br}, {2'b10, 8'd1, 8'd2, 8'd5, 8'd6});
            end
            tick();
        end
        bus4.out_ready = 1'b1;
        push4(8'd7);
        push4(8'd8);
        bus4.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (q4.size() - b !== 2) begin
            failures++;
            $display("FAIL stall_count got=%0d required=2", q4.size() - b);
        end
        for (int i = 0; i < 2 && b + i < q4.size(); i++) begin
            checks++;
            if (q4[b+i] !== e[i]) begin
                failures++;
                $display("FAIL stall_win%0d got=%h required=%h", i, q4[b+i], e[i]);
            end
        end
        checks++;
        if (fd4 - f !== 1) begin
            failures++;
            $display("FAIL stall_frame_done got=%0d required=1", fd4 - f);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e[4];
        int b, f;
        e = '{win(1'b0, 8'd1, 8'd2, 8'd5, 8'd6), win(1'b1, 8'd3, 8'd4, 8'd7, 8'd8),
              win(1'b0, 8'd11, 8'd12, 8'd15, 8'd16), win(1'b1, 8'd13, 8'd14, 8'd17, 8'd18)};
        b = q4.size(); f = fd4;
        bus4.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push4(8'(i));
        for (int i = 11; i <= 18; i++) push4(8'(i));
        bus4.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (q4.size() - b !== 4) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=4", q4.size() - b);
        end
        for (int i = 0; i < 4 && b + i < q4.size(); i++) begin
            checks++;
            if (q4[b+i] !== e[i]) begin
                failures++;
                $display("FAIL b2b_win%0d got=%h required=%h", i, q4[b+i], e[i]);
            end
        end
        checks++;
        if (fd4 - f !== 2) begin
            failures++;
            $display("FAIL b2b_frame_done got=%0d required=2", fd4 - f);
        end
    endtask

    task automatic test_mid_reset();
        logic [32:0] e[2];
        int b, f;
        e = '{win(1'b0, 8'd21, 8'd22, 8'd25, 8'd26), win(1'b1, 8'd23, 8'd24, 8'd27, 8'd28)};
        bus4.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push4(8'(i));
        bus4.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus4.win_valid, bus4.frame_done} !== 2'b00) begin
            failures++;
            $display("FAIL midreset_outputs got=%b required=00", {bus4.win_valid, bus4.frame_done});
        end
        tick();
        reset = 1'b1;
        b = q4.size(); f = fd4;
        for (int i = 21; i <= 28; i++) push4(8'(i));
        bus4.in_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (q4.size() - b !== 2) begin
            failures++;
            $display("FAIL midreset_count got=%0d required=2", q4.size() - b);
        end
        for (int i = 0; i < 2 && b + i < q4.size(); i++) begin
            checks++;
            if (q4[b+i] !== e[i]) begin
                failures++;
                $display("FAIL midreset_win%0d got=%h required=%h", i, q4[b+i], e[i]);
            end
        end
        checks++;
        if (fd4 - f !== 1) begin
            failures++;
            $display("FAIL midreset_frame_done got=%0d required=1", fd4 - f);
        end
    endtask

    task automatic test_random_8x8();
        logic [32:0] e;
        int b, f, k;
        b = q8.size(); f = fd8;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                push8(pix(r, c));
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (q8.size() - b !== 16) begin
            failures++;
            $display("FAIL rand_count got=%0d required=16", q8.size() - b);
        end
        for (int wr = 0; wr < 4; wr++)
            for (int wc = 0; wc < 4; wc++) begin
                k = wr * 4 + wc;
                e = win(k == 15, pix(2*wr, 2*wc), pix(2*wr, 2*wc+1), pix(2*wr+1, 2*wc), pix(2*wr+1, 2*wc+1));
                if (b + k < q8.size()) begin
                    checks++;
                    if (q8[b+k] !== e) begin
                        failures++;
                        $display("FAIL rand_win%0d got=%h required=%h", k, q8[b+k], e);
                    end
                    checks++;
                    if (max4(q8[b+k]) !== pix(2*wr+1, 2*wc+1)) begin
                        failures++;
                        $display("FAIL rand_max%0d got=%0d required=%0d", k, max4(q8[b+k]), pix(2*wr+1, 2*wc+1));
                    end
                end
            end
        checks++;
        if (fd8 - f !== 1) begin
            failures++;
            $display("FAIL rand_frame_done got=%0d required=1", fd8 - f);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random_8x8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
